plugboard_programmable: RTL and testbench

//  Runtime-programmable Enigma plugboard. Up to MAX_PAIRS symmetric letter swaps are loaded through a valid/ready config port.

---
 rtl/plugboard_pkg.sv | 33 +++
 rtl/plugboard_if.sv | 29 ++
 rtl/plugboard_onehot_encode.sv | 26 ++
 rtl/plugboard_programmable.sv | 153 +++++++++++++++
 tb/tb_plugboard_programmable.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/plugboard_pkg.sv
// Shared definitions for the programmable plugboard: defaults, FSM states, letter helpers.
package plugboard_pkg;

  localparam int unsigned NUM_LETTERS_DEF = 26;
  localparam int unsigned IDX_W_DEF       = 5;
  localparam int unsigned MAX_PAIRS_DEF   = 10;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WR_A  = 2'd2,
    S_WR_B  = 2'd3
  } state_e;

  typedef logic [NUM_LETTERS_DEF-1:0] letter_t;
  typedef logic [IDX_W_DEF-1:0]       idx_t;

  // Index to one-hot letter; out-of-alphabet indices give an all-zero letter.
  function automatic letter_t idx_to_onehot(idx_t idx);
    return letter_t'(1) << idx;
  endfunction

  // One-hot letter to index (highest set bit wins for malformed input).
  function automatic idx_t onehot_to_idx(letter_t oh);
    idx_t r;
    r = '0;
    for (int i = 0; i < int'(NUM_LETTERS_DEF); i++) begin
      if (oh[i]) r = idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/plugboard_if.sv
// Lookup and configuration ports of the plugboard, with master/slave views.
interface plugboard_if #(
  parameter int unsigned NUM_LETTERS = plugboard_pkg::NUM_LETTERS_DEF,
  parameter int unsigned IDX_W       = plugboard_pkg::IDX_W_DEF
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LETTERS-1:0] in_letter;
  logic                   out_valid;
  logic [NUM_LETTERS-1:0] out_letter;
  logic                   out_err;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic                   cfg_clear;
  logic [IDX_W-1:0]       cfg_a;
  logic [IDX_W-1:0]       cfg_b;
  logic                   cfg_err;
  logic [IDX_W-1:0]       pair_count;

  modport master (
    output in_valid, in_letter, cfg_valid, cfg_clear, cfg_a, cfg_b,
    input  in_ready, out_valid, out_letter, out_err, cfg_ready, cfg_err, pair_count
  );

  modport slave (
    input  in_valid, in_letter, cfg_valid, cfg_clear, cfg_a, cfg_b,
    output in_ready, out_valid, out_letter, out_err, cfg_ready, cfg_err, pair_count
  );
endinterface

// File: rtl/plugboard_onehot_encode.sv
// One-hot letter to index encoder; valid only when exactly one bit is set.
module onehot_encode #(
  parameter int unsigned N     = plugboard_pkg::NUM_LETTERS_DEF,
  parameter int unsigned IDX_W = plugboard_pkg::IDX_W_DEF
) (
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  localparam int unsigned CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] cnt;

  // Population count plus position of the set bit.
  always_comb begin
    idx = '0;
    cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (onehot[i]) begin
        idx = IDX_W'(i);
        cnt = cnt + CNT_W'(1);
      end
    end
    valid = (cnt == CNT_W'(1));
  end
endmodule

// File: rtl/plugboard_programmable.sv
// Runtime-programmable plugboard: involutive swap table, 1-cycle registered lookup.
module plugboard_programmable
  import plugboard_pkg::*;
#(
  parameter int unsigned NUM_LETTERS = NUM_LETTERS_DEF,
  parameter int unsigned MAX_PAIRS   = MAX_PAIRS_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  plugboard_if.slave bus
);
  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       map_q [NUM_LETTERS];
  logic [IDX_W-1:0]       map_d [NUM_LETTERS];
  logic [NUM_LETTERS-1:0] plugged_q, plugged_d;
  logic [IDX_W-1:0]       pair_a_q, pair_a_d, pair_b_q, pair_b_d;
  logic [IDX_W-1:0]       pair_count_q, pair_count_d;
  logic                   in_ready_q, in_ready_d, cfg_ready_q, cfg_ready_d;
  logic                   out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [NUM_LETTERS-1:0] out_letter_q, out_letter_d;

  logic [IDX_W-1:0] in_idx_c;
  logic             in_onehot_c;
  logic             in_acc_c, cfg_acc_c, a_ok_c, b_ok_c, pair_ok_c;

  onehot_encode #(.N(NUM_LETTERS), .IDX_W(IDX_W)) u_enc (
    .onehot (bus.in_letter),
    .idx    (in_idx_c),
    .valid  (in_onehot_c)
  );

  // Handshakes and pair legality against the currently installed table.
  always_comb begin
    in_acc_c  = bus.in_valid  && in_ready_q;
    cfg_acc_c = bus.cfg_valid && cfg_ready_q;
    a_ok_c    = (bus.cfg_a < IDX_W'(NUM_LETTERS)) && !plugged_q[bus.cfg_a];
    b_ok_c    = (bus.cfg_b < IDX_W'(NUM_LETTERS)) && !plugged_q[bus.cfg_b];
    pair_ok_c = (bus.cfg_a != bus.cfg_b) && a_ok_c && b_ok_c &&
                (pair_count_q != IDX_W'(MAX_PAIRS));
  end

  // Next-state: table sweep/writes, config FSM, lookup result.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    map_d        = map_q;
    plugged_d    = plugged_q;
    pair_a_d     = pair_a_q;
    pair_b_d     = pair_b_q;
    pair_count_d = pair_count_q;
    out_letter_d = out_letter_q;
    out_err_d    = out_err_q;
    out_valid_d  = 1'b0;
    cfg_err_d    = 1'b0;

    // Lookup reads the table as it stands before any same-cycle config write.
    if (in_acc_c) begin
      out_valid_d  = 1'b1;
      out_err_d    = !in_onehot_c;
      out_letter_d = in_onehot_c ? (NUM_LETTERS'(1) << map_q[in_idx_c]) : '0;
    end

    case (state_q)
      S_CLEAR: begin
        map_d[ptr_q]     = ptr_q;
        plugged_d[ptr_q] = 1'b0;
        if (ptr_q == IDX_W'(NUM_LETTERS - 1)) begin
          state_d      = S_IDLE;
          ptr_d        = '0;
          pair_count_d = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      S_IDLE: begin
        if (cfg_acc_c) begin
          if (bus.cfg_clear) begin
            state_d = S_CLEAR;
            ptr_d   = '0;
          end else if (pair_ok_c) begin
            pair_a_d = bus.cfg_a;
            pair_b_d = bus.cfg_b;
            state_d  = S_WR_A;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_WR_A: begin
        map_d[pair_a_q]     = pair_b_q;
        plugged_d[pair_a_q] = 1'b1;
        state_d             = S_WR_B;
      end
      S_WR_B: begin
        map_d[pair_b_q]     = pair_a_q;
        plugged_d[pair_b_q] = 1'b1;
        pair_count_d        = pair_count_q + IDX_W'(1);
        state_d             = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    cfg_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      ptr_q        <= '0;
      map_q        <= '{default: '0};
      plugged_q    <= '0;
      pair_a_q     <= '0;
      pair_b_q     <= '0;
      pair_count_q <= '0;
      in_ready_q   <= 1'b0;
      cfg_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_letter_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      map_q        <= map_d;
      plugged_q    <= plugged_d;
      pair_a_q     <= pair_a_d;
      pair_b_q     <= pair_b_d;
      pair_count_q <= pair_count_d;
      in_ready_q   <= in_ready_d;
      cfg_ready_q  <= cfg_ready_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      cfg_err_q    <= cfg_err_d;
      out_letter_q <= out_letter_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_letter = out_letter_q;
  assign bus.out_err    = out_err_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.pair_count = pair_count_q;
endmodule

// File: tb/tb_plugboard_programmable.sv
// Scoreboard bench for plugboard_programmable.
module tb_plugboard_programmable;
  import plugboard_pkg::*;

  localparam int unsigned NL = 26;
  localparam int unsigned MP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plugboard_if #(.NUM_LETTERS(NL), .IDX_W(5)) bus ();

  plugboard_programmable #(.NUM_LETTERS(NL), .MAX_PAIRS(MP), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NL-1:0] letter;
    logic          err;
    int            due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           model[NL];
  bit [NL-1:0]  pl_m;
  int           cnt_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_identity();
    for (int i = 0; i < int'(NL); i++) model[i] = i;
    pl_m  = '0;
    cnt_m = 0;
  endtask

  function automatic bit model_pair_ok(input int a, input int b);
    if (a == b || a >= int'(NL) || b >= int'(NL)) return 1'b0;
    if (pl_m[a] || pl_m[b] || cnt_m >= int'(MP)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t predict(input logic [NL-1:0] l);
    exp_t e;
    e.letter = '0;
    e.err    = 1'b1;
    e.due    = 0;
    if ($countones(l) == 1) begin
      for (int i = 0; i < int'(NL); i++)
        if (l[i]) e.letter = idx_to_onehot(5'(model[i]));
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Assumes the caller sits just after a rising edge.
  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic lookup(input logic [NL-1:0] l);
    exp_t e;
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_letter = l;
    @(posedge clk); #1;
    e     = predict(l);
    e.due = cyc;
    sb.push_back(e);
    bus.in_valid  = 1'b0;
    bus.in_letter = '0;
  endtask

  task automatic apply_pair(input int a, input int b);
    model[a] = b;
    model[b] = a;
    pl_m[a]  = 1'b1;
    pl_m[b]  = 1'b1;
    cnt_m++;
  endtask

  // Pair request, optionally with a simultaneous lookup of letter l.
  task automatic cfg_pair(input int a, input int b, input bit with_lookup, input logic [NL-1:0] l);
    bit   ok;
    exp_t e;
    wait_ready();
    ok            = model_pair_ok(a, b);
    bus.cfg_valid = 1'b1;
    bus.cfg_clear = 1'b0;
    bus.cfg_a     = 5'(a);
    bus.cfg_b     = 5'(b);
    bus.in_valid  = with_lookup;
    bus.in_letter = l;
    @(posedge clk); #1;
    if (with_lookup) begin
      e     = predict(l);
      e.due = cyc;
      sb.push_back(e);
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_letter = '0;
    check_val("cfg_err", 32'(bus.cfg_err), 32'(!ok));
    if (ok) apply_pair(a, b);
    @(posedge clk); #1;
    check_val("cfg_err_pulse", 32'(bus.cfg_err), 32'd0);
    wait_ready();
    check_val("pair_count", 32'(bus.pair_count), 32'(cnt_m));
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val(tag, 32'(n), 32'(NL));
    model_identity();
    check_val("pair_count_after_clear", 32'(bus.pair_count), 32'd0);
  endtask

  task automatic clear_all();
    wait_ready();
    bus.cfg_valid = 1'b1;
    bus.cfg_clear = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    bus.cfg_clear = 1'b0;
    check_val("cfg_ready_low", 32'(bus.cfg_ready), 32'd0);
    count_clear("clear_cycles");
  endtask

  task automatic check_all();
    for (int i = 0; i < int'(NL); i++) lookup(idx_to_onehot(5'(i)));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every result must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("latency", 32'(cyc), 32'(e.due));
        check_val("out_letter", 32'(bus.out_letter), 32'(e.letter));
        check_val("out_err", 32'(bus.out_err), 32'(e.err));
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_letter = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_clear = 1'b0;
    bus.cfg_a     = '0;
    bus.cfg_b     = '0;
    model_identity();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_letter", 32'(bus.out_letter), 32'd0);
    check_val("rst_out_err", 32'(bus.out_err), 32'd0);
    check_val("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check_val("rst_pair_count", 32'(bus.pair_count), 32'd0);
    rst = 1'b0;
    count_clear("reset_clear_cycles");
    check_all();
    wait_drain();

    // Single pair (A, Z)
    cfg_pair(0, 25, 1'b0, '0);
    lookup(26'd1);
    lookup(26'd33554432);
    lookup(26'd2);
    wait_drain();

    // Rejected pairs leave the table unchanged
    cfg_pair(25, 3, 1'b0, '0);
    check_all();
    cfg_pair(4, 4, 1'b0, '0);
    check_all();
    cfg_pair(26, 1, 1'b0, '0);
    check_all();
    for (int i = 0; i < 9; i++) cfg_pair(2 * i + 1, 2 * i + 2, 1'b0, '0);
    cfg_pair(19, 20, 1'b0, '0);
    check_val("pair_count_full", 32'(bus.pair_count), 32'(MP));
    check_all();

    // Malformed lookups
    lookup(26'd0);
    lookup(26'd3);
    lookup({NL{1'b1}});
    wait_drain();

    // Clear with pairs installed
    clear_all();
    check_all();
    wait_drain();

    // Reset while a pair is half written
    cfg_pair(2, 7, 1'b0, '0);
    lookup(26'd4);
    wait_drain();
    wait_ready();
    bus.cfg_valid = 1'b1;
    bus.cfg_a     = 5'd5;
    bus.cfg_b     = 5'd9;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_out_letter", 32'(bus.out_letter), 32'd0);
    check_val("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("arst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check_val("arst_pair_count", 32'(bus.pair_count), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    count_clear("rerst_clear_cycles");
    check_all();
    wait_drain();

    // Simultaneous lookup and pair accept: lookup sees the old mapping
    cfg_pair(3, 10, 1'b1, 26'd8);
    lookup(26'd8);
    lookup(26'd1024);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
